// File: rtl/adc_sample_averager.sv
// adc_sample_averager: drives a serial ADC, averages 2^AVG_LOG2 sign-magnitude samples.
// Ports: clk, reset, adc_start, adc_sdo in; adc_cs_n, adc_sclk, adc_busy, adc_data[15:0], adc_valid out.
module adc_sample_averager #(
  parameter int CLK_DIV  = 4,
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adc_start,
  input  logic        adc_sdo,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_busy,
  output logic [15:0] adc_data,
  output logic        adc_valid
);

  localparam int ACCW = 16 + AVG_LOG2;
  localparam int DIVW = $clog2(CLK_DIV);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [4:0] NSAMP = 5'(1 << AVG_LOG2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_AVG,
    S_DONE
  } state_t;

  state_t r_state;
  logic [DIVW-1:0] r_div;
  logic [3:0] r_bit;
  logic [14:0] r_sh;
  logic [ACCW-1:0] r_acc;
  logic [4:0] r_nsamp;
  logic r_cs_n;
  logic r_sclk;
  logic r_busy;
  logic r_valid;
  logic [15:0] r_data;

  logic [15:0] w_word;
  logic [ACCW-1:0] w_ext;
  logic [ACCW-1:0] w_samp;
  logic [ACCW-1:0] w_sum;
  logic [ACCW-1:0] w_abs;
  logic [ACCW-1:0] w_q;
  logic w_neg;

  // The last bit is folded in combinationally so the
  // sample is accumulated on the same edge it completes.
  assign w_word = {r_sh, adc_sdo};
  assign w_ext  = {{(AVG_LOG2 + 1){1'b0}}, w_word[14:0]};
  // Negative zero negates to zero, so it needs no special case.
  assign w_samp = w_word[15] ? -w_ext : w_ext;
  assign w_sum  = r_acc + w_samp;

  // Divide the magnitude so the result truncates toward zero.
  assign w_abs = r_acc[ACCW-1] ? -r_acc : r_acc;
  assign w_q   = w_abs >> AVG_LOG2;
  assign w_neg = r_acc[ACCW-1] && (w_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_acc   <= '0;
      r_nsamp <= '0;
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (adc_start) begin
            r_state <= S_SETUP;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_div   <= '0;
            r_acc   <= '0;
            r_nsamp <= '0;
          end
        end
        S_SETUP: begin
          if (r_div == DIV_LAST) begin
            r_state <= S_SHIFT;
            r_div   <= '0;
            r_bit   <= '0;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_div != DIV_LAST) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              // End of the high phase: capture this bit.
              r_sclk <= 1'b0;
              r_sh   <= {r_sh[13:0], adc_sdo};
              if (r_bit == 4'd15) begin
                r_state <= S_HOLD;
                r_cs_n  <= 1'b1;
                r_acc   <= w_sum;
                r_nsamp <= r_nsamp + 5'd1;
              end else begin
                r_bit <= r_bit + 4'd1;
              end
            end
          end
        end
        S_HOLD: begin
          if (r_div != DIV_LAST) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (r_nsamp == NSAMP) begin
              r_state <= S_AVG;
            end else begin
              r_state <= S_SETUP;
              r_cs_n  <= 1'b0;
            end
          end
        end
        S_AVG: begin
          r_data  <= {w_neg, w_q[14:0]};
          r_valid <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign adc_cs_n  = r_cs_n;
  assign adc_sclk  = r_sclk;
  assign adc_busy  = r_busy;
  assign adc_data  = r_data;
  assign adc_valid = r_valid;

endmodule

// File: tb/tb_adc_sample_averager.sv
// tb_adc_sample_averager: directed checks of the ADC averager
// with serial ADC models and a protocol monitor.
module tb_adc_sample_averager;

  localparam int CD = 4;

  logic clk;
  logic reset;

  logic adc_start, adc_sdo, adc_cs_n, adc_sclk;
  logic adc_busy, adc_valid;
  logic [15:0] adc_data;

  logic start1, sdo1, cs_n1, sclk1, busy1, valid1;
  logic [15:0] data1;

  int n_assert;
  int n_fail;

  adc_sample_averager u_dut (
    .clk(clk),
    .reset(reset),
    .adc_start(adc_start),
    .adc_sdo(adc_sdo),
    .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk),
    .adc_busy(adc_busy),
    .adc_data(adc_data),
    .adc_valid(adc_valid)
  );

  adc_sample_averager #(
    .CLK_DIV(2),
    .AVG_LOG2(0)
  ) u_dut1 (
    .clk(clk),
    .reset(reset),
    .adc_start(start1),
    .adc_sdo(sdo1),
    .adc_cs_n(cs_n1),
    .adc_sclk(sclk1),
    .adc_busy(busy1),
    .adc_data(data1),
    .adc_valid(valid1)
  );

  always #5 clk = ~clk;

  logic [15:0] smp [4];
  int sidx;
  logic [15:0] mdl_sh;
  logic [15:0] mdl_word;

  always @(negedge adc_cs_n) begin
    mdl_word = smp[sidx % 4];
    sidx++;
    mdl_sh = mdl_word;
    adc_sdo = mdl_sh[15];
  end

  always @(negedge adc_sclk) begin
    if (adc_cs_n === 1'b0) begin
      mdl_sh = {mdl_sh[14:0], 1'b0};
      adc_sdo = mdl_sh[15];
    end
  end

  logic [15:0] word1;
  logic [15:0] sh1;

  always @(negedge cs_n1) begin
    sh1 = word1;
    sdo1 = sh1[15];
  end

  always @(negedge sclk1) begin
    if (cs_n1 === 1'b0) begin
      sh1 = {sh1[14:0], 1'b0};
      sdo1 = sh1[15];
    end
  end

  logic m_pcs, m_psclk, m_first;
  int m_run, m_edges;
  logic [15:0] m_word;

  always @(negedge clk) begin
    if (reset) begin
      m_pcs = 1'b1;
      m_psclk = 1'b0;
      m_first = 1'b1;
      m_run = 0;
      m_edges = 0;
      m_word = '0;
    end else begin
      if (adc_cs_n !== m_pcs) begin
        n_assert++;
        if (adc_sclk !== 1'b0) begin
          n_fail++;
          $display("FAIL mon_sclk_at_cs: sclk=%b want 0", adc_sclk);
        end
        if (adc_cs_n === 1'b1) begin
          n_assert++;
          if (m_edges != 16) begin
            n_fail++;
            $display("FAIL mon_edges: got %0d want 16", m_edges);
          end
          n_assert++;
          if (m_word !== mdl_word) begin
            n_fail++;
            $display("FAIL mon_word: got %h want %h", m_word, mdl_word);
          end
        end
        m_edges = 0;
        m_first = 1'b1;
      end
      if (adc_sclk !== m_psclk) begin
        if (adc_sclk === 1'b1) begin
          m_edges++;
          m_word = {m_word[14:0], adc_sdo};
          if (!m_first) begin
            n_assert++;
            if (m_run != CD) begin
              n_fail++;
              $display("FAIL mon_low_half: got %0d want %0d", m_run, CD);
            end
          end
          m_first = 1'b0;
        end else begin
          n_assert++;
          if (m_run != CD) begin
            n_fail++;
            $display("FAIL mon_high_half: got %0d want %0d", m_run, CD);
          end
        end
        m_run = 1;
      end else begin
        m_run++;
      end
      m_pcs = adc_cs_n;
      m_psclk = adc_sclk;
    end
  end

  task automatic set_smp(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    smp[0] = a;
    smp[1] = b;
    smp[2] = c;
    smp[3] = d;
    sidx = 0;
  endtask

  task automatic run_meas(input int ign_a, input int ign_b,
                          output int vcyc, output logic [15:0] vdata,
                          output int nvalid, output int nwin,
                          output int fcyc, output logic c1_cs,
                          output logic c1_busy);
    int cyc;
    logic pcs;
    vcyc = -1;
    vdata = '0;
    nvalid = 0;
    nwin = 0;
    fcyc = -1;
    adc_start = 1'b1;
    @(posedge clk);
    #1;
    adc_start = 1'b0;
    cyc = 1;
    pcs = 1'b1;
    c1_cs = adc_cs_n;
    c1_busy = adc_busy;
    while (cyc <= 700 && fcyc < 0) begin
      if (pcs && !adc_cs_n) nwin++;
      pcs = adc_cs_n;
      if (adc_valid) begin
        nvalid++;
        if (vcyc < 0) begin
          vcyc = cyc;
          vdata = adc_data;
        end
      end
      if (cyc > 1 && !adc_busy) begin
        fcyc = cyc;
      end else begin
        adc_start = (cyc == ign_a || cyc == ign_b);
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    adc_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if (adc_cs_n !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_cs_n: got %b want 1", adc_cs_n);
    end
    n_assert++;
    if (adc_sclk !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_sclk: got %b want 0", adc_sclk);
    end
    n_assert++;
    if (adc_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy: got %b want 0", adc_busy);
    end
    n_assert++;
    if (adc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %b want 0", adc_valid);
    end
    n_assert++;
    if (adc_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_data: got %h want 0000", adc_data);
    end
    n_assert++;
    if (cs_n1 !== 1'b1 || data1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_dut1: got cs_n=%b data=%h want 1/0000", cs_n1, data1);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_sample(input logic [15:0] w, input logic [15:0] exp_d);
    int cyc, vcyc, nv, fcyc;
    logic [15:0] vd;
    word1 = w;
    vcyc = -1;
    nv = 0;
    fcyc = -1;
    vd = '0;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    cyc = 1;
    while (cyc <= 200 && fcyc < 0) begin
      if (valid1) begin
        nv++;
        if (vcyc < 0) begin
          vcyc = cyc;
          vd = data1;
        end
      end
      if (cyc > 1 && !busy1) begin
        fcyc = cyc;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    n_assert++;
    if (vcyc !== 70) begin
      n_fail++;
      $display("FAIL single_vcyc: got %0d want 70", vcyc);
    end
    n_assert++;
    if (vd !== exp_d) begin
      n_fail++;
      $display("FAIL single_data: got %h want %h", vd, exp_d);
    end
    n_assert++;
    if (fcyc !== 71 || nv !== 1) begin
      n_fail++;
      $display("FAIL single_fall: got fall=%0d nvalid=%0d want 71/1", fcyc, nv);
    end
  endtask

  task automatic test_positive_average();
    int vcyc, nv, nw, fcyc;
    logic [15:0] vd;
    logic c1c, c1b;
    set_smp(16'd100, 16'd102, 16'd104, 16'd106);
    run_meas(0, 0, vcyc, vd, nv, nw, fcyc, c1c, c1b);
    n_assert++;
    if (c1c !== 1'b0 || c1b !== 1'b1) begin
      n_fail++;
      $display("FAIL pos_cycle1: got cs_n=%b busy=%b want 0/1", c1c, c1b);
    end
    n_assert++;
    if (vcyc !== 546) begin
      n_fail++;
      $display("FAIL pos_vcyc: got %0d want 546", vcyc);
    end
    n_assert++;
    if (vd !== 16'h0067) begin
      n_fail++;
      $display("FAIL pos_data: got %h want 0067", vd);
    end
    n_assert++;
    if (nw !== 4) begin
      n_fail++;
      $display("FAIL pos_windows: got %0d want 4", nw);
    end
    n_assert++;
    if (nv !== 1 || fcyc !== 547) begin
      n_fail++;
      $display("FAIL pos_fall: got nvalid=%0d fall=%0d want 1/547", nv, fcyc);
    end
    n_assert++;
    if (adc_data !== 16'h0067) begin
      n_fail++;
      $display("FAIL pos_hold: got %h want 0067", adc_data);
    end
  endtask

  logic [15:0] tv [7][5] = '{
    '{16'h000A, 16'h8003, 16'h8003, 16'h8003, 16'h0000},
    '{16'h8005, 16'h8006, 16'h8006, 16'h8006, 16'h8005},
    '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000},
    '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF},
    '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
    '{16'h8001, 16'h8001, 16'h0000, 16'h0000, 16'h0000},
    '{16'h8009, 16'h0002, 16'h8003, 16'h0001, 16'h8002}
  };

  task automatic test_truncation_sign();
    int vcyc, nv, nw, fcyc;
    logic [15:0] vd;
    logic c1c, c1b;
    for (int k = 0; k < 7; k++) begin
      set_smp(tv[k][0], tv[k][1], tv[k][2], tv[k][3]);
      run_meas(0, 0, vcyc, vd, nv, nw, fcyc, c1c, c1b);
      n_assert++;
      if (vd !== tv[k][4] || vcyc !== 546) begin
        n_fail++;
        $display("FAIL trunc_%0d: got data=%h at %0d want %h at 546",
                 k, vd, vcyc, tv[k][4]);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int cyc, nv, vcyc, nw, fcyc;
    logic [15:0] vd;
    logic c1c, c1b;
    set_smp(16'd100, 16'd200, 16'd300, 16'd400);
    adc_start = 1'b1;
    @(posedge clk);
    #1;
    adc_start = 1'b0;
    cyc = 1;
    while (cyc < 190) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_assert++;
    if (adc_cs_n !== 1'b0 || adc_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: got cs_n=%b busy=%b want 0/1", adc_cs_n, adc_busy);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_assert++;
    if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b0 || adc_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outs: got cs_n=%b sclk=%b busy=%b want 1/0/0",
               adc_cs_n, adc_sclk, adc_busy);
    end
    nv = 0;
    for (int i = 0; i < 600; i++) begin
      if (adc_valid || adc_busy) nv++;
      @(posedge clk);
      #1;
    end
    n_assert++;
    if (nv !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", nv);
    end
    set_smp(16'd50, 16'd50, 16'd50, 16'd50);
    run_meas(0, 0, vcyc, vd, nv, nw, fcyc, c1c, c1b);
    n_assert++;
    if (vd !== 16'h0032 || vcyc !== 546) begin
      n_fail++;
      $display("FAIL abort_next: got data=%h at %0d want 0032 at 546", vd, vcyc);
    end
  endtask

  task automatic test_back_to_back();
    int vcyc, nv, nw, fcyc;
    logic [15:0] vd;
    logic c1c, c1b;
    set_smp(16'd10, 16'd20, 16'd30, 16'd40);
    run_meas(10, 300, vcyc, vd, nv, nw, fcyc, c1c, c1b);
    n_assert++;
    if (vcyc !== 546 || nv !== 1 || nw !== 4) begin
      n_fail++;
      $display("FAIL ign_start: got v=%0d n=%0d win=%0d want 546/1/4", vcyc, nv, nw);
    end
    n_assert++;
    if (vd !== 16'h0019) begin
      n_fail++;
      $display("FAIL ign_data: got %h want 0019", vd);
    end
    set_smp(16'h8064, 16'h8064, 16'h8064, 16'h8064);
    run_meas(0, 0, vcyc, vd, nv, nw, fcyc, c1c, c1b);
    n_assert++;
    if (c1c !== 1'b0 || vcyc !== 546 || nv !== 1) begin
      n_fail++;
      $display("FAIL b2b_start: got cs_n=%b v=%0d n=%0d want 0/546/1", c1c, vcyc, nv);
    end
    n_assert++;
    if (vd !== 16'h8064) begin
      n_fail++;
      $display("FAIL b2b_data: got %h want 8064", vd);
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    adc_start = 1'b0;
    adc_sdo = 1'b0;
    start1 = 1'b0;
    sdo1 = 1'b0;
    word1 = '0;
    sidx = 0;
    mdl_word = '0;
    mdl_sh = '0;
    n_assert = 0;
    n_fail = 0;
    for (int i = 0; i < 4; i++) smp[i] = '0;
    test_reset();
    test_single_sample(16'h0123, 16'h0123);
    test_single_sample(16'h8000, 16'h0000);
    test_positive_average();
    test_truncation_sign();
    test_reset_mid_shift();
    test_back_to_back();
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_sample_averager.md
# adc_sample_averager

Upstream front-end for the temperature calculator. Drives a serial ADC, reads 2^AVG_LOG2 consecutive 16-bit sign-magnitude conversions, and averages them. It presents one averaged word on `adc_data` with a single-cycle `adc_valid` strobe. `adc_data` uses the same sign-magnitude format the temperature calculator consumes: bit 15 is the sign, bits 14:0 are the magnitude.

## Interface
- `CLK_DIV`, default 4, number of `clk` cycles per SCLK half-period; must be ≥ 2.
- `AVG_LOG2`, default 2, log2 of samples per average; legal range 0..4.
- `clk` input 1: single system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `adc_start` input 1: request one averaged measurement; sampled only in IDLE.
- `adc_sdo` input 1: serial data from the ADC, MSB first.
- `adc_cs_n` output 1: ADC chip select, active low.
- `adc_sclk` output 1: ADC serial clock.
- `adc_busy` output 1: high in every state except IDLE.
- `adc_data` output 16: averaged result in sign-magnitude; holds its value until the next strobe.
- `adc_valid` output 1: one-cycle strobe that qualifies `adc_data`.

## Operation
- States and transitions:
  - IDLE → SETUP when `adc_start`=1.
  - SETUP (CLK_DIV cycles, CS low, SCLK low) → SHIFT.
  - SHIFT runs 16 bits. Each bit is CLK_DIV cycles SCLK low, then CLK_DIV cycles SCLK high.
  - SHIFT → HOLD after bit 16.
  - HOLD (CLK_DIV cycles, CS high) → SETUP if samples taken < 2^AVG_LOG2; otherwise → AVG.
  - AVG (1 cycle) → DONE.
  - DONE (1 cycle, `adc_valid`=1) → IDLE.
- Bit capture: `adc_sdo` is captured on the clk edge that ends each SCLK-high phase. Bits are shifted in MSB first.
- Per-sample conversion: the 16-bit sign-magnitude word is converted to two's complement. 0x8000 (negative zero) converts to 0.
- Accumulation: a signed accumulator of 16+AVG_LOG2 bits is cleared on entry from IDLE. No overflow is possible.
- Averaging in AVG:
  - mag = floor(|sum| / 2^AVG_LOG2), which truncates toward zero.
  - sign = 1 only if sum < 0 and mag ≠ 0. Negative zero is never output.
  - `adc_data` = {sign, mag[14:0]}, registered at the end of AVG.
- `adc_start` outside IDLE is ignored; it is neither queued nor allowed to restart the sequence.
- `reset` mid-operation aborts immediately:
  - returns to IDLE;
  - clears the accumulator and sample counter;
  - produces no `adc_valid` for the aborted measurement.

## Timing
- Reset values: `adc_cs_n`=1, `adc_sclk`=0, `adc_busy`=0, `adc_valid`=0, `adc_data`=16'h0000, state IDLE.
- Start timing: `adc_start` sampled high at edge 0 puts `adc_cs_n` low and `adc_busy` high from cycle 1.
- One sample takes 34·CLK_DIV cycles: CLK_DIV SETUP + 32·CLK_DIV SHIFT + CLK_DIV HOLD.
- `adc_valid` is high exactly in cycle 2^AVG_LOG2·34·CLK_DIV + 2 after the start edge.
  - With defaults this is cycle 546.
  - `adc_data` changes in that same cycle.
- `adc_busy` falls in the cycle after DONE. A new `adc_start` is accepted in that cycle, so measurements can run back-to-back.
- All outputs are registered and glitch-free. SCLK edges fall only on `clk` edges.
- `adc_cs_n` is high for at least CLK_DIV cycles between samples.

## Test plan
- **Single sample:** AVG_LOG2=0, CLK_DIV=2, ADC model returns 0x0123 → `adc_valid` at cycle 70, `adc_data`=0x0123, `adc_busy` low the next cycle.
- **Positive average:** defaults, samples +100, +102, +104, +106 → `adc_data`=0x0067 (103), `adc_valid` exactly at cycle 546, exactly four CS low windows.
- **Truncation and sign:**
  - samples +10, −3, −3, −3 (sum +1) → 0x0000;
  - samples −5, −6, −6, −6 (sum −23) → 0x8005;
  - samples 0x8000 ×4 → 0x0000.
- **Reset mid-SHIFT:** assert `reset` for 1 cycle during bit 7 of sample 2 → next cycle `adc_cs_n`=1, `adc_sclk`=0, `adc_busy`=0, no `adc_valid`. A following start with samples 50 ×4 yields 0x0032, with no contamination from the aborted run.
- **Ignored start / back-to-back:** pulse `adc_start` at cycles 10 and 300 → no restart, single `adc_valid` at 546. Start again in the cycle `adc_busy` falls → accepted, second strobe 546 cycles after that start.
- **Serial protocol check:** monitor asserts the following for every sample:
  - SCLK low whenever CS transitions;
  - 16 rising SCLK edges per CS window;
  - SCLK half-period = CLK_DIV;
  - captured word matches the model's MSB-first stream.
